// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: set-mode state codes, keypad codes,
// time limits and a BCD pair to binary helper.
package clock_pkg;

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] HT     = 3'd1;
    localparam logic [2:0] HO     = 3'd2;
    localparam logic [2:0] MT     = 3'd3;
    localparam logic [2:0] MO     = 3'd4;
    localparam logic [2:0] COMMIT = 3'd5;

    localparam logic [3:0] KEY_SKIP   = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return ({2'b00, tens} * 6'd10) + {2'b00, ones};
    endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Combinational 6-bit binary (0-63) to two BCD digits.
module bin2bcd6 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [3:0] tens_s;

    // Threshold ladder instead of a divider; the range is tiny.
    always_comb begin
        if (bin >= 6'd60)      tens_s = 4'd6;
        else if (bin >= 6'd50) tens_s = 4'd5;
        else if (bin >= 6'd40) tens_s = 4'd4;
        else if (bin >= 6'd30) tens_s = 4'd3;
        else if (bin >= 6'd20) tens_s = 4'd2;
        else if (bin >= 6'd10) tens_s = 4'd1;
        else                   tens_s = 4'd0;
    end

    // The remainder is < 10, so modulo-16 arithmetic on the low nibble is exact.
    assign tens = tens_s;
    assign ones = bin[3:0] - (tens_s * 4'd10);

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: snapshots the running time, edits four BCD fields
// from the keypad with 24-hour validation, and strobes the result into the counter.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic       set_time,
    output logic [5:0] key_hour,
    output logic [5:0] key_minute,
    output logic [2:0] twinkle,
    output logic       blink_on,
    output logic       setting
);

    localparam int              CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BLINK_DIV - 1);

    logic [2:0]    state_r, state_nx_s;
    logic [3:0]    ht_r, ho_r, mt_r, mo_r;
    logic [3:0]    ht_nx_s, ho_nx_s, mt_nx_s, mo_nx_s;
    logic [3:0]    snap_ht_s, snap_ho_s, snap_mt_s, snap_mo_s;
    logic          digit_ok_s;
    logic          abort_s;
    logic          set_time_r, setting_r, blink_r;
    logic [CW-1:0] cnt_r;

    bin2bcd6 u_hour_bcd (
        .bin  (cur_hour),
        .tens (snap_ht_s),
        .ones (snap_ho_s)
    );

    bin2bcd6 u_min_bcd (
        .bin  (cur_minute),
        .tens (snap_mt_s),
        .ones (snap_mo_s)
    );

    // Legal digit range for the field currently being edited.
    always_comb begin
        case (state_r)
            HT:      digit_ok_s = (key_code <= 4'd2);
            HO:      digit_ok_s = (ht_r == 4'd2) ? (key_code <= 4'd3) : (key_code <= 4'd9);
            MT:      digit_ok_s = (key_code <= 4'd5);
            MO:      digit_ok_s = (key_code <= 4'd9);
            default: digit_ok_s = 1'b0;
        endcase
    end

    assign abort_s = change || (key_valid && (key_code == KEY_CANCEL));

    // Next state and next edit-register values; abort outranks any key.
    always_comb begin
        state_nx_s = state_r;
        ht_nx_s    = ht_r;
        ho_nx_s    = ho_r;
        mt_nx_s    = mt_r;
        mo_nx_s    = mo_r;
        case (state_r)
            RUN: begin
                if (change) begin
                    ht_nx_s    = snap_ht_s;
                    ho_nx_s    = snap_ho_s;
                    mt_nx_s    = snap_mt_s;
                    mo_nx_s    = snap_mo_s;
                    state_nx_s = HT;
                end else begin
                    state_nx_s = RUN;
                end
            end
            HT, HO, MT, MO: begin
                if (abort_s) begin
                    state_nx_s = RUN;
                end else if (key_valid && (key_code == KEY_SKIP)) begin
                    state_nx_s = state_r + 3'd1;
                end else if (key_valid && digit_ok_s) begin
                    state_nx_s = state_r + 3'd1;
                    case (state_r)
                        HT: begin
                            ht_nx_s = key_code;
                            // A tens digit of 2 caps the hour at 23.
                            if ((key_code == 4'd2) && (ho_r > 4'd3)) begin
                                ho_nx_s = 4'd3;
                            end else begin
                                ho_nx_s = ho_r;
                            end
                        end
                        HO:      ho_nx_s = key_code;
                        MT:      mt_nx_s = key_code;
                        MO:      mo_nx_s = key_code;
                        default: ht_nx_s = ht_r;
                    endcase
                end else begin
                    state_nx_s = state_r;
                end
            end
            COMMIT:  state_nx_s = RUN;
            default: state_nx_s = RUN;
        endcase
    end

    // State, edit registers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RUN;
            ht_r       <= 4'd0;
            ho_r       <= 4'd0;
            mt_r       <= 4'd0;
            mo_r       <= 4'd0;
            set_time_r <= 1'b0;
            setting_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ht_r       <= ht_nx_s;
            ho_r       <= ho_nx_s;
            mt_r       <= mt_nx_s;
            mo_r       <= mo_nx_s;
            set_time_r <= (state_nx_s == COMMIT);
            setting_r  <= (state_nx_s != RUN);
        end
    end

    // Blink phase: restarts visible on every state change, frozen in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            blink_r <= 1'b1;
        end else if ((state_nx_s != state_r) || (state_r == RUN)) begin
            cnt_r   <= '0;
            blink_r <= 1'b1;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            blink_r <= ~blink_r;
        end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            blink_r <= blink_r;
        end
    end

    assign twinkle    = state_r;
    assign set_time   = set_time_r;
    assign setting    = setting_r;
    assign blink_on   = blink_r;
    assign key_hour   = bcd_to_bin(ht_r, ho_r);
    assign key_minute = bcd_to_bin(mt_r, mo_r);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a field-level behavioural model checked every cycle.
module tb_time_set_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       change = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [5:0] cur_hour = 6'd0;
    logic [5:0] cur_minute = 6'd0;
    logic       set_time;
    logic [5:0] key_hour;
    logic [5:0] key_minute;
    logic [2:0] twinkle;
    logic       blink_on;
    logic       setting;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    // Model: current field index (0 run .. 5 commit), time as plain integers,
    // and cycles spent in the current field.
    int m_f = 0, m_hour = 0, m_min = 0, m_age = 0;

    time_set_ctrl #(.BLINK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .change     (change),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .cur_hour   (cur_hour),
        .cur_minute (cur_minute),
        .set_time   (set_time),
        .key_hour   (key_hour),
        .key_minute (key_minute),
        .twinkle    (twinkle),
        .blink_on   (blink_on),
        .setting    (setting)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        int nf, nh, nm, d, ones, tens;
        if (!rst) begin
            m_f    <= 0;
            m_hour <= 0;
            m_min  <= 0;
            m_age  <= 0;
        end else begin
            nf = m_f; nh = m_hour; nm = m_min; d = int'(key_code);
            if (m_f == 0) begin
                if (change) begin
                    nh = int'(cur_hour); nm = int'(cur_minute); nf = 1;
                end
            end else if (m_f == 5) begin
                nf = 0;
            end else if (change || (key_valid && d == 11)) begin
                nf = 0;
            end else if (key_valid && d == 10) begin
                nf = m_f + 1;
            end else if (key_valid && d <= 9) begin
                case (m_f)
                    1: if (d <= 2) begin
                           ones = m_hour % 10;
                           if (d == 2 && ones > 3) ones = 3;
                           nh = d * 10 + ones; nf = 2;
                       end
                    2: begin
                           tens = m_hour / 10;
                           if (d <= ((tens == 2) ? 3 : 9)) begin
                               nh = tens * 10 + d; nf = 3;
                           end
                       end
                    3: if (d <= 5) begin
                           nm = d * 10 + m_min % 10; nf = 4;
                       end
                    default: begin
                           nm = (m_min / 10) * 10 + d; nf = 5;
                       end
                endcase
            end
            m_f    <= nf;
            m_hour <= nh;
            m_min  <= nm;
            m_age  <= (nf != m_f || nf == 0) ? 0 : m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("twinkle", int'(twinkle), m_f);
            chk("setting", int'(setting), (m_f != 0) ? 1 : 0);
            chk("set_time", int'(set_time), (m_f == 5) ? 1 : 0);
            chk("key_hour", int'(key_hour), m_hour);
            chk("key_minute", int'(key_minute), m_min);
            chk("blink_on", int'(blink_on), (m_f == 0 || ((m_age / DIV) % 2) == 0) ? 1 : 0);
            if (set_time) pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic chg();
        change = 1'b1;
        tick();
        change = 1'b0;
    endtask

    initial begin
        int pat [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        chk_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_twinkle", int'(twinkle), 0);
        chk("rst_setting", int'(setting), 0);
        chk("rst_blink", int'(blink_on), 1);
        chk("rst_key_hour", int'(key_hour), 0);
        tick();

        // Full edit 13:45 -> 21:30
        cur_hour = 6'd13; cur_minute = 6'd45;
        chg();
        chk("snap_twinkle", int'(twinkle), 1);
        chk("snap_hour", int'(key_hour), 13);
        chk("snap_min", int'(key_minute), 45);
        press(4'd2); press(4'd1); press(4'd3); press(4'd0);
        chk("t1_strobe", int'(set_time), 1);
        chk("t1_twinkle", int'(twinkle), 5);
        chk("t1_hour", int'(key_hour), 21);
        chk("t1_min", int'(key_minute), 30);
        tick();
        chk("t1_run_twinkle", int'(twinkle), 0);
        chk("t1_run_setting", int'(setting), 0);
        chk("t1_pulses", pulses, 1);

        // Clamp 19:07 -> 23:07 with skips
        cur_hour = 6'd19; cur_minute = 6'd7;
        chg();
        press(4'd2);
        chk("clamp_hour", int'(key_hour), 23);
        press(4'd5);
        chk("ho_reject", int'(twinkle), 2);
        press(4'd3); press(KEY_SKIP_C()); press(KEY_SKIP_C());
        chk("t2_strobe", int'(set_time), 1);
        chk("t2_hour", int'(key_hour), 23);
        chk("t2_min", int'(key_minute), 7);
        tick();

        // Illegal digits, then cancel in MT
        cur_hour = 6'd22; cur_minute = 6'd15;
        chg();
        press(4'd3);
        chk("ht_reject", int'(twinkle), 1);
        press(4'd2);
        press(4'd9);
        chk("ho9_reject", int'(twinkle), 2);
        press(4'd3);
        press(4'd6);
        chk("mt_reject", int'(twinkle), 3);
        press(4'hB);
        chk("cancel_twinkle", int'(twinkle), 0);
        chk("cancel_setting", int'(setting), 0);
        chk("cancel_hour_kept", int'(key_hour), 23);

        // change together with a key in HO
        chg();
        press(4'd1);
        change = 1'b1; key_valid = 1'b1; key_code = 4'd5;
        tick();
        change = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        chk("chgkey_twinkle", int'(twinkle), 0);
        chk("chgkey_hour", int'(key_hour), 12);
        tick();
        chk("abort_pulses", pulses, 2);

        // Blink pattern while idle in HT
        cur_hour = 6'd10; cur_minute = 6'd20;
        chg();
        chk("blink_0", int'(blink_on), pat[0]);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("blink_pat", int'(blink_on), pat[i]);
        end
        repeat (3) tick();
        chk("blink_mid", int'(blink_on), 0);
        press(4'd1);
        chk("blink_restart", int'(blink_on), 1);
        chk("blink_restart_tw", int'(twinkle), 2);
        press(4'd0); press(4'd3);
        chk("mo_reached", int'(twinkle), 4);

        // Asynchronous reset between edges while in MO
        #2 rst = 1'b0;
        #1;
        chk("arst_twinkle", int'(twinkle), 0);
        chk("arst_setting", int'(setting), 0);
        chk("arst_set_time", int'(set_time), 0);
        chk("arst_blink", int'(blink_on), 1);
        chk("arst_hour", int'(key_hour), 0);
        chk("arst_min", int'(key_minute), 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        cur_hour = 6'd8; cur_minute = 6'd59;
        chg();
        chk("post_rst_hour", int'(key_hour), 8);
        chk("post_rst_min", int'(key_minute), 59);
        press(4'hB);
        tick();
        chk("final_pulses", pulses, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [3:0] KEY_SKIP_C();
        return 4'hA;
    endfunction

endmodule
